// File: rtl/vend_pkg.sv
// Shared definitions for the vending payout path: amount width, coin values, payout FSM encoding.
package vend_pkg;

    localparam int CNT_W     = 3;
    localparam int COIN1_VAL = 1;
    localparam int COIN2_VAL = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_FIRE,
        ST_WAIT_DROP,
        ST_DONE,
        ST_FAULT
    } pay_state_t;

    typedef enum logic {
        SRC_CNG = 1'b0,
        SRC_RTN = 1'b1
    } pay_src_t;

    typedef enum logic {
        HOP_H1 = 1'b0,
        HOP_H2 = 1'b1
    } hopper_t;

endpackage

// File: rtl/payout_timer.sv
// Per-coin pulse-width and drop-timeout down-counters, both (re)loaded by start.
// pulse_active stays high while more fire cycles follow the current one; timeout pulses at expiry.
module payout_timer #(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic pulse_active,
    output logic timeout
);

    localparam int PW = (PULSE_CYCLES   > 1) ? $clog2(PULSE_CYCLES)   : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_run_q, to_run_d;

    // Loaded with N-1 so that the start-following cycle is the first of N counted cycles.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        to_cnt_d    = to_cnt_q;
        to_run_d    = to_run_q;
        if (start) begin
            pulse_cnt_d = PW'(PULSE_CYCLES - 1);
            to_cnt_d    = TW'(TIMEOUT_CYCLES - 1);
            to_run_d    = 1'b1;
        end else begin
            if (pulse_cnt_q != '0) begin
                pulse_cnt_d = pulse_cnt_q - PW'(1);
            end
            if (to_run_q) begin
                if (to_cnt_q == '0) begin
                    to_run_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q - TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_cnt_q <= '0;
            to_cnt_q    <= '0;
            to_run_q    <= 1'b0;
        end else begin
            pulse_cnt_q <= pulse_cnt_d;
            to_cnt_q    <= to_cnt_d;
            to_run_q    <= to_run_d;
        end
    end

    assign pulse_active = (pulse_cnt_q != '0);
    assign timeout      = to_run_q && (to_cnt_q == '0);

endmodule

// File: rtl/coin_payout_scheduler.sv
// Arbitrates change/refund jobs onto the value-1/value-2 hoppers, paying greedily one coin per fire/sense.
// Strobe to first fire is 3 cycles; a strobe into an occupied slot is dropped and flagged in overrun.
module coin_payout_scheduler #(
    parameter int CNT_W          = vend_pkg::CNT_W,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cng_req,
    input  logic [CNT_W-1:0] cng_amt,
    input  logic             rtn_req,
    input  logic [CNT_W-1:0] rtn_amt,
    input  logic             h1_empty,
    input  logic             h2_empty,
    input  logic             h1_sense,
    input  logic             h2_sense,
    input  logic             fault_clr,
    output logic             h1_fire,
    output logic             h2_fire,
    output logic             busy,
    output logic             req_ack,
    output logic             done,
    output logic             done_src,
    output logic             fault,
    output logic [CNT_W-1:0] shortfall,
    output logic             overrun
);

    import vend_pkg::*;

    pay_state_t       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    pay_src_t         src_q, src_d;
    hopper_t          sel_q, sel_d;
    logic             seen_q, seen_d;
    logic             cng_vld_q, cng_vld_d;
    logic [CNT_W-1:0] cng_amt_q, cng_amt_d;
    logic             rtn_vld_q, rtn_vld_d;
    logic [CNT_W-1:0] rtn_amt_q, rtn_amt_d;
    logic             req_ack_q, req_ack_d;
    logic             overrun_q, overrun_d;

    logic             tmr_start;
    logic             pulse_active;
    logic             timeout;
    logic             sense_sel;
    logic             sense_oth;
    logic [CNT_W-1:0] coin_val;

    payout_timer #(
        .PULSE_CYCLES  (PULSE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .start       (tmr_start),
        .pulse_active(pulse_active),
        .timeout     (timeout)
    );

    assign sense_sel = (sel_q == HOP_H2) ? h2_sense : h1_sense;
    assign sense_oth = (sel_q == HOP_H2) ? h1_sense : h2_sense;
    assign coin_val  = (sel_q == HOP_H2) ? CNT_W'(COIN2_VAL) : CNT_W'(COIN1_VAL);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        src_d     = src_q;
        sel_d     = sel_q;
        seen_d    = seen_q;
        cng_vld_d = cng_vld_q;
        cng_amt_d = cng_amt_q;
        rtn_vld_d = rtn_vld_q;
        rtn_amt_d = rtn_amt_q;
        req_ack_d = 1'b0;
        overrun_d = overrun_q;
        tmr_start = 1'b0;
        h1_fire   = 1'b0;
        h2_fire   = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;

        // Slot capture runs in every state; the FSM load below frees a slot at the same edge.
        if (cng_req) begin
            if (cng_vld_q) begin
                overrun_d = 1'b1;
            end else begin
                cng_vld_d = 1'b1;
                cng_amt_d = cng_amt;
                req_ack_d = 1'b1;
            end
        end
        if (rtn_req) begin
            if (rtn_vld_q) begin
                overrun_d = 1'b1;
            end else begin
                rtn_vld_d = 1'b1;
                rtn_amt_d = rtn_amt;
                req_ack_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rtn_vld_q) begin
                    rem_d     = rtn_amt_q;
                    src_d     = SRC_RTN;
                    rtn_vld_d = 1'b0;
                    state_d   = ST_SELECT;
                end else if (cng_vld_q) begin
                    rem_d     = cng_amt_q;
                    src_d     = SRC_CNG;
                    cng_vld_d = 1'b0;
                    state_d   = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if ((rem_q >= CNT_W'(COIN2_VAL)) && !h2_empty) begin
                    sel_d     = HOP_H2;
                    seen_d    = 1'b0;
                    tmr_start = 1'b1;
                    state_d   = ST_FIRE;
                end else if (!h1_empty) begin
                    sel_d     = HOP_H1;
                    seen_d    = 1'b0;
                    tmr_start = 1'b1;
                    state_d   = ST_FIRE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_FIRE: begin
                h1_fire = (sel_q == HOP_H1);
                h2_fire = (sel_q == HOP_H2);
                if (sense_oth) begin
                    state_d = ST_FAULT;
                end else begin
                    if (sense_sel) begin
                        seen_d = 1'b1;
                    end
                    if (timeout && !seen_q && !sense_sel) begin
                        state_d = ST_FAULT;
                    end else if (!pulse_active) begin
                        state_d = ST_WAIT_DROP;
                    end
                end
            end
            ST_WAIT_DROP: begin
                if (sense_oth) begin
                    state_d = ST_FAULT;
                end else if (sense_sel || seen_q) begin
                    rem_d   = rem_q - coin_val;
                    state_d = ST_SELECT;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                fault = 1'b1;
                if (fault_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            src_q     <= SRC_CNG;
            sel_q     <= HOP_H1;
            seen_q    <= 1'b0;
            cng_vld_q <= 1'b0;
            cng_amt_q <= '0;
            rtn_vld_q <= 1'b0;
            rtn_amt_q <= '0;
            req_ack_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            src_q     <= src_d;
            sel_q     <= sel_d;
            seen_q    <= seen_d;
            cng_vld_q <= cng_vld_d;
            cng_amt_q <= cng_amt_d;
            rtn_vld_q <= rtn_vld_d;
            rtn_amt_q <= rtn_amt_d;
            req_ack_q <= req_ack_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign req_ack   = req_ack_q;
    assign done_src  = (src_q == SRC_RTN);
    assign shortfall = (state_q == ST_FAULT) ? rem_q : '0;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_coin_payout_scheduler.sv
// Directed bench for coin_payout_scheduler with an auto-responding hopper model.
module tb_coin_payout_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       cng_req, rtn_req;
    logic [2:0] cng_amt, rtn_amt;
    logic       h1_empty, h2_empty;
    logic       h1_sense = 1'b0;
    logic       h2_sense = 1'b0;
    logic       fault_clr;
    logic       h1_fire, h2_fire, busy, req_ack, done, done_src, fault, overrun;
    logic [2:0] shortfall;

    int n_tests = 0;
    int n_fail  = 0;

    coin_payout_scheduler #(
        .CNT_W(3), .PULSE_CYCLES(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst),
        .cng_req(cng_req), .cng_amt(cng_amt),
        .rtn_req(rtn_req), .rtn_amt(rtn_amt),
        .h1_empty(h1_empty), .h2_empty(h2_empty),
        .h1_sense(h1_sense), .h2_sense(h2_sense),
        .fault_clr(fault_clr),
        .h1_fire(h1_fire), .h2_fire(h2_fire),
        .busy(busy), .req_ack(req_ack), .done(done), .done_src(done_src),
        .fault(fault), .shortfall(shortfall), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Hopper model: one sense pulse in the cycle after the first low cycle of each fire pulse.
    logic auto_sense = 1'b1;
    logic p1 = 1'b0, p2 = 1'b0, f1 = 1'b0, f2 = 1'b0;
    always @(posedge clk) begin
        #2;
        h1_sense = auto_sense && f1;
        h2_sense = auto_sense && f2;
        f1 = p1 && !h1_fire;
        f2 = p2 && !h2_fire;
        p1 = h1_fire;
        p2 = h2_fire;
    end

    int          c1 = 0, c2 = 0, w1 = 0, w2 = 0, badw = 0, ndone = 0, dual = 0;
    logic [31:0] src_hist = '0, fire_hist = '0;
    always @(posedge clk) begin
        #3;
        if (h1_fire) w1++;
        else if (w1 != 0) begin
            c1++;
            if (w1 != 4) badw++;
            fire_hist = {fire_hist[30:0], 1'b0};
            w1 = 0;
        end
        if (h2_fire) w2++;
        else if (w2 != 0) begin
            c2++;
            if (w2 != 4) badw++;
            fire_hist = {fire_hist[30:0], 1'b1};
            w2 = 0;
        end
        if (h1_fire && h2_fire) dual++;
        if (done) begin
            ndone++;
            src_hist = {src_hist[30:0], done_src};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dones(input int target, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            if (ndone >= target) break;
            tick();
        end
        check({tag, "_done_cnt"}, ndone, target);
    endtask

    function automatic logic [10:0] outs();
        return {h1_fire, h2_fire, busy, req_ack, done, done_src, fault, shortfall, overrun};
    endfunction

    int b1, b2, bd, bw;

    task automatic snap();
        b1 = c1; b2 = c2; bd = ndone; bw = badw;
    endtask

    initial begin
        rst = 1'b1; cng_req = 1'b0; rtn_req = 1'b0; cng_amt = '0; rtn_amt = '0;
        h1_empty = 1'b0; h2_empty = 1'b0; fault_clr = 1'b0;
        tick(); tick();
        check("reset_outs", 32'(outs()), 0);
        rst = 1'b0;
        tick();
        check("idle_outs", 32'(outs()), 0);

        // 1: change of 3 -> one value-2 coin then one value-1 coin
        snap();
        cng_amt = 3'd3; cng_req = 1'b1;
        tick(); cng_req = 1'b0;
        check("t1_ack_c1", req_ack, 1);
        check("t1_busy_c1", busy, 0);
        tick();
        check("t1_c2_busy_nofire", {busy, h1_fire, h2_fire}, 3'b100);
        tick();
        check("t1_c3_h2_fire", {h1_fire, h2_fire}, 2'b01);
        wait_dones(bd + 1, 200, "t1");
        check("t1_busy_after", busy, 0);
        check("t1_h1_coins", c1 - b1, 1);
        check("t1_h2_coins", c2 - b2, 1);
        check("t1_order_h2_h1", fire_hist[1:0], 2'b10);
        check("t1_done_src", src_hist[0], 0);
        check("t1_widths", badw - bw, 0);

        // 2: simultaneous requests, refund wins
        snap();
        cng_amt = 3'd2; cng_req = 1'b1; rtn_amt = 3'd1; rtn_req = 1'b1;
        tick(); cng_req = 1'b0; rtn_req = 1'b0;
        check("t2_ack", req_ack, 1);
        wait_dones(bd + 2, 300, "t2");
        check("t2_h1_coins", c1 - b1, 1);
        check("t2_h2_coins", c2 - b2, 1);
        check("t2_order_h1_h2", fire_hist[1:0], 2'b01);
        check("t2_src_rtn_then_cng", src_hist[1:0], 2'b10);
        check("t2_busy_after", busy, 0);

        // 3: refund of 5 with value-2 hopper empty
        snap();
        h2_empty = 1'b1;
        rtn_amt = 3'd5; rtn_req = 1'b1;
        tick(); rtn_req = 1'b0;
        wait_dones(bd + 1, 400, "t3");
        repeat (10) tick();
        check("t3_single_done", ndone - bd, 1);
        check("t3_h1_coins", c1 - b1, 5);
        check("t3_h2_coins", c2 - b2, 0);
        check("t3_widths", badw - bw, 0);
        check("t3_done_src", src_hist[0], 1);
        h2_empty = 1'b0;

        // 4: one unit owed with value-1 hopper empty
        snap();
        h1_empty = 1'b1;
        cng_amt = 3'd1; cng_req = 1'b1;
        tick(); cng_req = 1'b0;
        tick(); tick();
        check("t4_fault_c3", {fault, shortfall, h1_fire, h2_fire, busy}, {1'b1, 3'd1, 1'b0, 1'b0, 1'b1});
        repeat (5) tick();
        check("t4_fault_held", {fault, shortfall}, {1'b1, 3'd1});
        check("t4_no_coins", (c1 - b1) + (c2 - b2), 0);
        fault_clr = 1'b1;
        tick(); fault_clr = 1'b0;
        check("t4_cleared", {busy, fault, shortfall}, 5'b0);
        h1_empty = 1'b0;

        // 5: no sense -> timeout; second strobe into the pending slot
        auto_sense = 1'b0;
        cng_amt = 3'd2; cng_req = 1'b1;
        tick();
        check("t5_ack", req_ack, 1);
        cng_amt = 3'd1;
        tick(); cng_req = 1'b0;
        check("t5_overrun_noack", {overrun, req_ack}, 2'b10);
        tick();
        check("t5_h2_fire_c3", h2_fire, 1);
        repeat (63) tick();
        check("t5_no_fault_c66", {fault, h2_fire}, 2'b00);
        tick();
        check("t5_fault_c67", {fault, shortfall, h1_fire, h2_fire}, {1'b1, 3'd2, 1'b0, 1'b0});
        fault_clr = 1'b1;
        tick(); fault_clr = 1'b0;
        check("t5_idle", busy, 0);
        tick();
        check("t5_no_dropped_job", busy, 0);
        check("t5_overrun_sticky", overrun, 1);
        auto_sense = 1'b1;

        // 6: reset while value-2 hopper is firing
        snap();
        cng_amt = 3'd2; cng_req = 1'b1;
        tick(); cng_req = 1'b0;
        tick(); tick();
        check("t6_h2_fire", h2_fire, 1);
        tick();
        rst = 1'b1;
        tick();
        check("t6_reset_outs", 32'(outs()), 0);
        rst = 1'b0;
        repeat (4) tick();
        check("t6_no_done", ndone - bd, 0);
        snap();
        rtn_amt = 3'd2; rtn_req = 1'b1;
        tick(); rtn_req = 1'b0;
        check("t6_ack", req_ack, 1);
        wait_dones(bd + 1, 200, "t6");
        check("t6_h2_coins", c2 - b2, 1);
        check("t6_h1_coins", c1 - b1, 0);
        check("t6_done_src", src_hist[0], 1);
        check("t6_widths", badw - bw, 0);
        check("t6_busy_after", busy, 0);

        check("never_dual_fire", dual, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
